// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM shifter-operand immediate encoder.
package arm_pkg;

  // Search states: direct pass, optional inverted pass, one-cycle result pulse.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEARCH     = 2'd1,
    SEARCH_INV = 2'd2,
    DONE       = 2'd3
  } imm_enc_state_t;

  localparam int ROT_STEPS = 16;  // rotate_imm values per pass
  localparam int ROT_W     = 4;   // width of rotate_imm
  localparam int IMM_W     = 8;   // width of immed_8
  localparam int SHOP_W    = 12;  // {rotate_imm, immed_8}

  // Rotate left by two bits: stepping the candidate by one rotate_imm unit.
  function automatic logic [31:0] rol2(input logic [31:0] x);
    return {x[29:0], x[31:30]};
  endfunction

endpackage

// File: rtl/imm_encoder_fit.sv
// Combinational fit test: a rotated candidate is encodable when only its
// low byte carries ones; that byte is then the immed_8 field.
import arm_pkg::*;

module imm_fit_check (
  input  logic [31:0]      work,
  output logic             fit,
  output logic [IMM_W-1:0] immed_8
);

  // One zero-detect per upper byte.
  logic [2:0] byte_zero;

  for (genvar gi = 0; gi < 3; gi++) begin : g_byte_zero
    assign byte_zero[gi] = (work[8*(gi+1) +: 8] == 8'h00);
  end

  assign fit     = &byte_zero;
  assign immed_8 = work[IMM_W-1:0];

endmodule

// File: rtl/imm_encoder.sv
// Iterative search for an ARM data-processing immediate {rotate_imm, immed_8}
// such that value == ROR(immed_8, 2*rotate_imm). One rotation is tested per
// cycle; when the direct pass fails, ~value may be tried (MOV->MVN, AND->BIC).
import arm_pkg::*;

module imm_encoder #(
  parameter bit ALLOW_INVERT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       value,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic              inverted,
  output logic [SHOP_W-1:0] shifter_operand
);

  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_STEPS - 1);

  imm_enc_state_t    state_q, state_d;
  logic [31:0]       work_q, work_d;      // candidate rotated left by 2*rot_cnt
  logic [31:0]       value_q, value_d;    // captured request, source of the inverted pass
  logic [ROT_W-1:0]  rot_cnt_q, rot_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              found_q, found_d;
  logic              inverted_q, inverted_d;
  logic [SHOP_W-1:0] shop_q, shop_d;

  logic              fit;
  logic [IMM_W-1:0]  immed_8;

  imm_fit_check u_fit (
    .work    (work_q),
    .fit     (fit),
    .immed_8 (immed_8)
  );

  // Next-state and registered-output logic for the search FSM.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    value_d    = value_q;
    rot_cnt_d  = rot_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    found_d    = found_q;
    inverted_d = inverted_q;
    shop_d     = shop_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          value_d    = value;
          work_d     = value;
          rot_cnt_d  = '0;
          busy_d     = 1'b1;
          found_d    = 1'b0;
          inverted_d = 1'b0;
          shop_d     = '0;
          state_d    = SEARCH;
        end
      end

      SEARCH, SEARCH_INV: begin
        if (fit) begin
          // First hit is the smallest rotate_imm of the current pass.
          shop_d     = {rot_cnt_q, immed_8};
          found_d    = 1'b1;
          inverted_d = (state_q == SEARCH_INV);
          busy_d     = 1'b0;
          state_d    = DONE;
        end else if (rot_cnt_q != ROT_LAST) begin
          work_d    = rol2(work_q);
          rot_cnt_d = rot_cnt_q + 1'b1;
        end else if ((state_q == SEARCH) && ALLOW_INVERT) begin
          work_d    = ~value_q;
          rot_cnt_d = '0;
          state_d   = SEARCH_INV;
        end else begin
          found_d    = 1'b0;
          inverted_d = 1'b0;
          shop_d     = '0;
          busy_d     = 1'b0;
          state_d    = DONE;
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any search in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      value_q    <= '0;
      rot_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      inverted_q <= 1'b0;
      shop_q     <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      value_q    <= value_d;
      rot_cnt_q  <= rot_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      found_q    <= found_d;
      inverted_q <= inverted_d;
      shop_q     <= shop_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign found           = found_q;
  assign inverted        = inverted_q;
  assign shifter_operand = shop_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: two instances (with and without the inverted pass)
// share stimulus; expectations come from a brute-force forward val2 model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value_in = 32'h0;

  logic        busy_a, done_a, found_a, inv_a;
  logic [11:0] so_a;
  logic        busy_b, done_b, found_b, inv_b;
  logic [11:0] so_b;

  imm_encoder #(.ALLOW_INVERT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .value(value_in),
    .busy(busy_a), .done(done_a), .found(found_a), .inverted(inv_a),
    .shifter_operand(so_a)
  );

  imm_encoder #(.ALLOW_INVERT(1'b0)) u_dut_ni (
    .clk(clk), .rst(rst), .start(start), .value(value_in),
    .busy(busy_b), .done(done_b), .found(found_b), .inverted(inv_b),
    .shifter_operand(so_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic        f;
    logic        i;
    logic [11:0] so;
    int          lat;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Forward val2 immediate generator: ROR({24'h0, immed_8}, 2*rotate_imm).
  function automatic logic [31:0] val2(input logic [11:0] so);
    logic [31:0] x;
    int s;
    x = {24'h0, so[7:0]};
    s = 2 * int'(so[11:8]);
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  // Exhaustive search over all 4096 encodings, smallest rotate first,
  // direct before inverted. Latency counts edges from the accepting edge.
  function automatic exp_t model(input logic [31:0] v, input bit allow_inv);
    exp_t e;
    logic [31:0] tgt;
    e.v = v; e.f = 1'b0; e.i = 1'b0; e.so = 12'h000;
    e.lat = allow_inv ? 33 : 17;
    for (int p = 0; p < 2; p++) begin
      if (!e.f && (p == 0 || allow_inv)) begin
        tgt = (p == 1) ? ~v : v;
        for (int r = 0; r < 16 && !e.f; r++) begin
          for (int m = 0; m < 256 && !e.f; m++) begin
            logic [11:0] c;
            c = {4'(r), 8'(m)};
            if (val2(c) == tgt) begin
              e.f = 1'b1; e.i = (p == 1); e.so = c; e.lat = p * 16 + r + 2;
            end
          end
        end
      end
    end
    return e;
  endfunction

  task automatic check_result(input string who, input exp_t e, input int cyc,
                              input logic f, input logic i, input logic [11:0] so);
    check({who, "_lat"}, cyc, e.lat);
    check({who, "_found"}, f, e.f);
    check({who, "_inv"}, i, e.i);
    check({who, "_so"}, so, e.so);
    if (f) check({who, "_roundtrip"}, val2(so), i ? ~e.v : e.v);
  endtask

  task automatic run_one(input logic [31:0] v);
    exp_t ea, eb;
    int cyc;
    bit got_a, got_b;
    sb_a.push_back(model(v, 1'b1));
    sb_b.push_back(model(v, 1'b0));
    ea = '{v: 32'h0, f: 1'b0, i: 1'b0, so: 12'h0, lat: 0};
    eb = ea;
    @(negedge clk);
    value_in = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    value_in = $urandom;  // changes after capture must not matter
    check("busy_a", busy_a, 1'b1);
    check("busy_b", busy_b, 1'b1);
    cyc = 0; got_a = 1'b0; got_b = 1'b0;
    while (!got_a && cyc < 40) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (done_b) begin
        if (got_b) check("dup_done_b", 1'b1, 1'b0);
        else begin
          got_b = 1'b1;
          eb = sb_b.pop_front();
          check_result("ni", eb, cyc, found_b, inv_b, so_b);
        end
      end
      if (done_a) begin
        got_a = 1'b1;
        ea = sb_a.pop_front();
        check_result("ai", ea, cyc, found_a, inv_a, so_a);
        $display("txn v=%h found=%0b inv=%0b so=%h lat=%0d | noinv found=%0b so=%h",
                 v, found_a, inv_a, so_a, cyc, found_b, so_b);
      end
      // A start while both are searching must be ignored.
      if (!got_a && cyc == 2 && busy_a && busy_b) begin
        start = 1'b1;
        value_in = 32'h0;
      end
    end
    if (!got_a) begin
      check("timeout_a", 1'b0, 1'b1);
      ea = sb_a.pop_front();
    end
    if (!got_b) begin
      check("timeout_b", 1'b0, 1'b1);
      eb = sb_b.pop_front();
    end
    @(posedge clk); #1;
    check("done_pulse_a", done_a, 1'b0);
    check("done_pulse_b", done_b, 1'b0);
    check("hold_found_a", found_a, ea.f);
    check("hold_so_a", so_a, ea.so);
  endtask

  task automatic run_reset;
    int seen;
    @(negedge clk);
    value_in = 32'h12345678;
    start = 1'b1;
    @(posedge clk); #1;         // edge T
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end   // through edge T+4
    rst = 1'b1;
    @(posedge clk); #1;         // edge T+5 samples reset
    rst = 1'b0;
    check("mrst_busy", busy_a, 1'b0);
    check("mrst_done", done_a, 1'b0);
    check("mrst_found", found_a, 1'b0);
    check("mrst_inv", inv_a, 1'b0);
    check("mrst_so", so_a, 12'h000);
    check("mrst_busy_b", busy_b, 1'b0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_a || done_b) seen++;
    end
    check("mrst_no_done", seen, 0);
    $display("txn mid-search reset v=12345678 done_pulses=%0d", seen);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] so_r;
    logic [31:0] v_r;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_found", found_a, 1'b0);
    check("rst_inv", inv_a, 1'b0);
    check("rst_so", so_a, 12'h000);
    rst = 1'b0;

    run_one(32'h000000FF);
    run_one(32'hFF000000);
    run_one(32'h00000104);
    run_one(32'hFFFFFF00);
    run_one(32'h12345678);
    run_one(32'h00000000);
    run_one(32'hFFFFFFFF);
    run_one(32'hC000003F);
    run_reset();
    run_one(32'h000003FC);
    for (int n = 0; n < 12; n++) begin
      so_r = 12'($urandom_range(0, 4095));
      v_r = val2(so_r);
      if ($urandom_range(0, 1) == 1) v_r = ~v_r;
      run_one(v_r);
    end
    for (int n = 0; n < 3; n++) run_one($urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
